// File: rtl/signature_pattern_table.sv
// Programmable table of authorised signature patterns with per-field wildcards.
// Each query is scanned one entry per cycle; the lowest matching enabled entry wins.
//
// state | meaning
// IDLE  | table writable, waiting for a query
// SCAN  | comparing the held query against entry r_idx
// RESP  | result presented until downstream takes it
module signature_pattern_table #(
    parameter int FIELD_W = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic               cfg_en,
    input  logic [3:0]         cfg_mask,
    input  logic [FIELD_W-1:0] cfg_region,
    input  logic [FIELD_W-1:0] cfg_auth_level,
    input  logic [FIELD_W-1:0] cfg_expiry,
    input  logic [FIELD_W-1:0] cfg_signature_id,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FIELD_W-1:0] region,
    input  logic [FIELD_W-1:0] auth_level,
    input  logic [FIELD_W-1:0] expiry,
    input  logic [FIELD_W-1:0] signature_id,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_match,
    output logic [IDX_W-1:0]   rsp_idx,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   hit_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DEPTH-1:0]   r_en;
    logic [3:0]         r_tbl_mask   [DEPTH];
    logic [FIELD_W-1:0] r_tbl_region [DEPTH];
    logic [FIELD_W-1:0] r_tbl_auth   [DEPTH];
    logic [FIELD_W-1:0] r_tbl_exp    [DEPTH];
    logic [FIELD_W-1:0] r_tbl_sig    [DEPTH];

    logic [FIELD_W-1:0] r_q_region;
    logic [FIELD_W-1:0] r_q_auth;
    logic [FIELD_W-1:0] r_q_exp;
    logic [FIELD_W-1:0] r_q_sig;

    logic [IDX_W-1:0]   r_idx;
    logic               r_rsp_match;
    logic [IDX_W-1:0]   r_rsp_idx;
    logic [CNT_W-1:0]   r_hit_count;

    logic w_cfg_wr;
    logic w_accept;
    logic w_hit;
    logic w_last;
    logic w_xfer;

    assign cfg_ready = (r_state == ST_IDLE) && !rst;
    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_match = r_rsp_match;
    assign rsp_idx   = r_rsp_idx;
    assign hit_count = r_hit_count;

    assign w_cfg_wr = cfg_we && cfg_ready;
    assign w_accept = req_valid && req_ready;
    assign w_last   = (r_idx == IDX_W'(DEPTH - 1));
    assign w_xfer   = rsp_valid && rsp_ready;

    // A masked field always compares true.
    assign w_hit = r_en[r_idx]
                && (r_tbl_mask[r_idx][0] || (r_tbl_region[r_idx] == r_q_region))
                && (r_tbl_mask[r_idx][1] || (r_tbl_auth[r_idx]   == r_q_auth))
                && (r_tbl_mask[r_idx][2] || (r_tbl_exp[r_idx]    == r_q_exp))
                && (r_tbl_mask[r_idx][3] || (r_tbl_sig[r_idx]    == r_q_sig));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)         w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_hit || w_last)  w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)        w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= '0;
        end else if (w_cfg_wr) begin
            r_en[cfg_addr] <= cfg_en;
        end
    end

    // Pattern contents are don't-care while disabled, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_tbl_mask[cfg_addr]   <= cfg_mask;
            r_tbl_region[cfg_addr] <= cfg_region;
            r_tbl_auth[cfg_addr]   <= cfg_auth_level;
            r_tbl_exp[cfg_addr]    <= cfg_expiry;
            r_tbl_sig[cfg_addr]    <= cfg_signature_id;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_region <= region;
            r_q_auth   <= auth_level;
            r_q_exp    <= expiry;
            r_q_sig    <= signature_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_rsp_match <= 1'b0;
            r_rsp_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_idx <= '0;
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        r_rsp_match <= 1'b1;
                        r_rsp_idx   <= r_idx;
                    end else if (w_last) begin
                        r_rsp_match <= 1'b0;
                        r_rsp_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_hit_count <= '0;
        end else if (w_xfer && r_rsp_match && (r_hit_count != {CNT_W{1'b1}})) begin
            r_hit_count <= r_hit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_signature_pattern_table.sv
// Directed bench for signature_pattern_table with a narrow hit counter so that
// saturation is reachable in a few queries.
module tb_signature_pattern_table;

    localparam int FIELD_W = 8;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic               cfg_ready;
    logic [IDX_W-1:0]   cfg_addr;
    logic               cfg_en;
    logic [3:0]         cfg_mask;
    logic [FIELD_W-1:0] cfg_region, cfg_auth_level, cfg_expiry, cfg_signature_id;
    logic               req_valid;
    logic               req_ready;
    logic [FIELD_W-1:0] region, auth_level, expiry, signature_id;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_match;
    logic [IDX_W-1:0]   rsp_idx;
    logic               cnt_clr;
    logic [CNT_W-1:0]   hit_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    signature_pattern_table #(.FIELD_W(FIELD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .cfg_mask(cfg_mask), .cfg_region(cfg_region), .cfg_auth_level(cfg_auth_level),
        .cfg_expiry(cfg_expiry), .cfg_signature_id(cfg_signature_id),
        .req_valid(req_valid), .req_ready(req_ready),
        .region(region), .auth_level(auth_level), .expiry(expiry), .signature_id(signature_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_match(rsp_match), .rsp_idx(rsp_idx),
        .cnt_clr(cnt_clr), .hit_count(hit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] a, input logic en, input logic [3:0] m,
                           input logic [7:0] r, input logic [7:0] au,
                           input logic [7:0] e, input logic [7:0] s);
        cfg_addr = a; cfg_en = en; cfg_mask = m;
        cfg_region = r; cfg_auth_level = au; cfg_expiry = e; cfg_signature_id = s;
    endtask

    task automatic wr(input logic [2:0] a, input logic en, input logic [3:0] m,
                      input logic [7:0] r, input logic [7:0] au,
                      input logic [7:0] e, input logic [7:0] s);
        set_cfg(a, en, m, r, au, e, s);
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Issue one query, check latency and result, optionally stall the response
    // (attempting a table write meanwhile), then complete the transfer.
    task automatic run_q(input logic [7:0] r, input logic [7:0] au, input logic [7:0] e,
                         input logic [7:0] s, input logic exp_m, input logic [2:0] exp_i,
                         input int exp_lat, input int stall, input logic clr_at_xfer,
                         input string tag);
        int  lat;
        bit  got;
        req_valid = 1'b1;
        region = r; auth_level = au; expiry = e; signature_id = s;
        chk({tag, ".req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cfg_we = 1'b0;
        region = 8'($urandom); auth_level = 8'($urandom);
        expiry = 8'($urandom); signature_id = 8'($urandom);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) got = 1;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".match"}, rsp_match, exp_m);
        chk({tag, ".idx"}, rsp_idx, exp_i);
        for (int i = 0; i < stall; i++) begin
            set_cfg(3'd7, 1'b1, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
            cfg_we = 1'b1;
            @(posedge clk); #1;
            cfg_we = 1'b0;
            chk({tag, ".stall_valid"}, rsp_valid, 1);
            chk({tag, ".stall_match"}, rsp_match, exp_m);
            chk({tag, ".stall_idx"}, rsp_idx, exp_i);
            chk({tag, ".stall_req_ready"}, req_ready, 0);
            chk({tag, ".stall_cfg_ready"}, cfg_ready, 0);
        end
        rsp_ready = 1'b1;
        cnt_clr = clr_at_xfer;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cnt_clr = 1'b0;
        if (clr_at_xfer) exp_cnt = 0;
        else if (exp_m && exp_cnt < 3) exp_cnt++;
        chk({tag, ".hit_count"}, hit_count, exp_cnt);
        chk({tag, ".rsp_valid_after"}, rsp_valid, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        cfg_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
        set_cfg(3'd0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        region = 8'h00; auth_level = 8'h00; expiry = 8'h00; signature_id = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.rsp_match", rsp_match, 0);
        chk("rst.rsp_idx", rsp_idx, 0);
        chk("rst.hit_count", hit_count, 0);
        chk("rst.cfg_ready", cfg_ready, 1);
        chk("rst.req_ready", req_ready, 1);

        // T3: empty table misses after a full scan
        run_q(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 3'd0, 8, 0, 1'b0, "t3_empty");

        // T1: exact match at entry 0
        wr(3'd0, 1'b1, 4'h0, 8'h0A, 8'h01, 8'h10, 8'hF3);
        run_q(8'h0A, 8'h01, 8'h10, 8'hF3, 1'b1, 3'd0, 1, 0, 1'b0, "t1_e0");

        // T2: disabled entry 2 is skipped, entry 5 wins
        wr(3'd2, 1'b0, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44);
        wr(3'd5, 1'b1, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44);
        run_q(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 3'd5, 6, 0, 1'b0, "t2_e5");

        // T4: wildcard sig/exp on entry 3
        wr(3'd3, 1'b1, 4'b1100, 8'h0A, 8'h01, 8'h55, 8'h66);
        run_q(8'h0A, 8'h01, 8'hFF, 8'h00, 1'b1, 3'd3, 4, 0, 1'b0, "t4_wild_hit");
        run_q(8'h0A, 8'h02, 8'hFF, 8'h00, 1'b0, 3'd0, 8, 0, 1'b0, "t4_auth_miss");

        // T5: clear, stalled response with ignored write, saturation, clear vs hit
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        exp_cnt = 0;
        chk("t5.clr", hit_count, 0);
        run_q(8'h0A, 8'h01, 8'h10, 8'hF3, 1'b1, 3'd0, 1, 4, 1'b0, "t5_stall");
        run_q(8'h77, 8'h77, 8'h77, 8'h77, 1'b0, 3'd0, 8, 0, 1'b0, "t5_write_ignored");
        for (int k = 0; k < 4; k++)
            run_q(8'h0A, 8'h01, 8'h10, 8'hF3, 1'b1, 3'd0, 1, 0, 1'b0, "t5_sat");
        chk("t5.saturated", hit_count, 3);
        run_q(8'h0A, 8'h01, 8'h10, 8'hF3, 1'b1, 3'd0, 1, 0, 1'b1, "t5_clr_prio");

        // All-wild entry matches anything not caught earlier
        wr(3'd6, 1'b1, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        run_q(8'h77, 8'h77, 8'h77, 8'h77, 1'b1, 3'd6, 7, 0, 1'b0, "allmask_e6");

        // Write and accept in the same cycle: the query sees the new entry 1
        set_cfg(3'd1, 1'b1, 4'h0, 8'h99, 8'h99, 8'h99, 8'h99);
        cfg_we = 1'b1;
        run_q(8'h99, 8'h99, 8'h99, 8'h99, 1'b1, 3'd1, 2, 0, 1'b0, "same_cycle_wr");

        // T6: reset during scan
        req_valid = 1'b1;
        region = 8'h11; auth_level = 8'h22; expiry = 8'h33; signature_id = 8'h44;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6.mid_scan", rsp_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6.rsp_valid_in_rst", rsp_valid, 0);
        rst = 1'b0;
        #1;
        chk("t6.req_ready", req_ready, 1);
        chk("t6.cfg_ready", cfg_ready, 1);
        chk("t6.hit_count", hit_count, 0);
        chk("t6.rsp_match", rsp_match, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("t6.no_response", seen, 0);
        exp_cnt = 0;
        run_q(8'h0A, 8'h01, 8'h10, 8'hF3, 1'b0, 3'd0, 8, 0, 1'b0, "t6_e0_gone");
        run_q(8'h77, 8'h77, 8'h77, 8'h77, 1'b0, 3'd0, 8, 0, 1'b0, "t6_e6_gone");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
